fetch_prefetch_queue: RTL and testbench

//  Instruction-fetch front end. Owns the fetch PC and drives it to the combinational instruction ROM.

---
 rtl/fetch_prefetch_queue_if.sv | 27 ++
 rtl/fetch_prefetch_queue.sv | 77 +++++++
 tb/tb_fetch_prefetch_queue.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// rtl/fetch_prefetch_queue_if.sv - fetch front end bus: ROM port, redirect, decode handshake
interface fetch_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   imem_pc;
  logic [31:0]   imem_instr;
  logic          fetch_en;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          id_valid;
  logic          id_ready;
  logic [31:0]   id_pc;
  logic [31:0]   id_instr;
  logic [CW-1:0] q_count;

  modport master (
    output imem_pc, id_valid, id_pc, id_instr, q_count,
    input  imem_instr, fetch_en, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_pc, id_valid, id_pc, id_instr, q_count,
    output imem_instr, fetch_en, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - fetch PC owner with {pc, instr} prefetch FIFO feeding decode
module fetch_prefetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                    clk,
  input logic                    reset_n,
  fetch_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          head_valid;
  logic          pop;
  logic          push;

  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus.id_ready & ~bus.redirect_valid;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign push       = bus.fetch_en & ~bus.redirect_valid & ((count_q < CW'(DEPTH)) | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_d       = wr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]    <= fetch_pc_q;
      instr_mem[wr_q] <= bus.imem_instr;
    end
  end

  assign bus.imem_pc  = fetch_pc_q;
  assign bus.id_valid = head_valid;
  assign bus.id_pc    = head_valid ? pc_mem[rd_q]    : 32'h0;
  assign bus.id_instr = head_valid ? instr_mem[rd_q] : NOP_INSTR;
  assign bus.q_count  = count_q;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  fetch_prefetch_queue_if #(.DEPTH(4)) bus ();

  fetch_prefetch_queue dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // ROM word i holds i+1.
  assign bus.imem_instr = (bus.imem_pc >> 2) + 32'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n            = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n            = 1'b0;
    bus.fetch_en       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;
    tick();
    tests_run++;
    if (bus.id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_id_valid: got %b expected 0", bus.id_valid); end
    tests_run++;
    if (bus.id_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_id_pc: got %h expected 00000000", bus.id_pc); end
    tests_run++;
    if (bus.id_instr !== 32'h13) begin tests_failed++; $display("FAIL reset_id_instr: got %h expected 00000013", bus.id_instr); end
    tests_run++;
    if (bus.q_count !== 3'd0) begin tests_failed++; $display("FAIL reset_q_count: got %0d expected 0", bus.q_count); end
    tests_run++;
    if (bus.imem_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_imem_pc: got %h expected 00000000", bus.imem_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if (bus.id_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, bus.id_valid); end
      tests_run++;
      if (bus.id_pc !== 32'(4 * k)) begin tests_failed++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, bus.id_pc, 32'(4 * k)); end
      tests_run++;
      if (bus.id_instr !== 32'(k + 1)) begin tests_failed++; $display("FAIL stream_instr[%0d]: got %h expected %h", k, bus.id_instr, 32'(k + 1)); end
      tests_run++;
      if (bus.q_count !== 3'd1) begin tests_failed++; $display("FAIL stream_count[%0d]: got %0d expected 1", k, bus.q_count); end
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.id_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests_run++;
      if (bus.q_count !== 3'((k > 4) ? 4 : k)) begin tests_failed++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, bus.q_count, (k > 4) ? 4 : k); end
      tests_run++;
      if (bus.id_pc !== 32'h0 || bus.id_instr !== 32'h1) begin tests_failed++; $display("FAIL fill_head_stable[%0d]: got %h/%h expected 00000000/00000001", k, bus.id_pc, bus.id_instr); end
    end
    tests_run++;
    if (bus.imem_pc !== 32'h10) begin tests_failed++; $display("FAIL fill_imem_hold: got %h expected 00000010", bus.imem_pc); end
    bus.id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (bus.id_pc !== 32'(4 * k) || bus.id_valid !== 1'b1) begin tests_failed++; $display("FAIL drain_pc[%0d]: got %h valid %b expected %h valid 1", k, bus.id_pc, bus.id_valid, 32'(4 * k)); end
      tick();
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.id_ready = 1'b0;
    repeat (4) tick();
    bus.id_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests_run++;
      if (bus.q_count !== 3'd4) begin tests_failed++; $display("FAIL full_count[%0d]: got %0d expected 4", k, bus.q_count); end
      tests_run++;
      if (bus.imem_pc !== 32'(16 + 4 * k)) begin tests_failed++; $display("FAIL full_imem_pc[%0d]: got %h expected %h", k, bus.imem_pc, 32'(16 + 4 * k)); end
      tests_run++;
      if (bus.id_instr !== 32'(k + 1)) begin tests_failed++; $display("FAIL full_head_instr[%0d]: got %h expected %h", k, bus.id_instr, 32'(k + 1)); end
    end
  endtask

  task automatic test_fetch_stall();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.id_ready = 1'b0;
    repeat (3) tick();
    bus.fetch_en = 1'b0;
    bus.id_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests_run++;
      if (bus.q_count !== 3'((k > 3) ? 0 : 3 - k)) begin tests_failed++; $display("FAIL stall_count[%0d]: got %0d expected %0d", k, bus.q_count, (k > 3) ? 0 : 3 - k); end
      tests_run++;
      if (bus.imem_pc !== 32'hC) begin tests_failed++; $display("FAIL stall_imem_pc[%0d]: got %h expected 0000000c", k, bus.imem_pc); end
    end
    tests_run++;
    if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h13) begin tests_failed++; $display("FAIL stall_empty: got valid %b instr %h expected 0/00000013", bus.id_valid, bus.id_instr); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.id_ready = 1'b0;
    repeat (3) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h103;
    tick();
    bus.redirect_valid = 1'b0;
    tests_run++;
    if (bus.q_count !== 3'd0 || bus.id_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_flush: got count %0d valid %b expected 0/0", bus.q_count, bus.id_valid); end
    tests_run++;
    if (bus.imem_pc !== 32'h100) begin tests_failed++; $display("FAIL redir_imem_pc: got %h expected 00000100", bus.imem_pc); end
    bus.id_ready = 1'b1;
    tick();
    tests_run++;
    if (bus.id_pc !== 32'h100 || bus.id_instr !== 32'h41) begin tests_failed++; $display("FAIL redir_head: got %h/%h expected 00000100/00000041", bus.id_pc, bus.id_instr); end
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h202;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tests_run++;
    if (bus.imem_pc !== 32'h200 || bus.q_count !== 3'd0) begin tests_failed++; $display("FAIL redir_noen: got pc %h count %0d expected 00000200/0", bus.imem_pc, bus.q_count); end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFFC;
    exp_pc[1] = 32'h0000_0000;
    exp_pc[2] = 32'h0000_0004;
    do_reset();
    bus.fetch_en       = 1'b1;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (bus.id_pc !== exp_pc[k]) begin tests_failed++; $display("FAIL wrap_pc[%0d]: got %h expected %h", k, bus.id_pc, exp_pc[k]); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.id_ready = 1'b0;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.q_count !== 3'd0 || bus.id_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_clear: got count %0d valid %b expected 0/0", bus.q_count, bus.id_valid); end
    tests_run++;
    if (bus.imem_pc !== 32'h0 || bus.id_instr !== 32'h13) begin tests_failed++; $display("FAIL areset_outputs: got pc %h instr %h expected 00000000/00000013", bus.imem_pc, bus.id_instr); end
    reset_n      = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    tests_run++;
    if (bus.id_pc !== 32'h0 || bus.id_instr !== 32'h1 || bus.q_count !== 3'd1) begin tests_failed++; $display("FAIL areset_restart: got %h/%h count %0d expected 00000000/00000001/1", bus.id_pc, bus.id_instr, bus.q_count); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_drain();
    test_full_push_pop();
    test_fetch_stall();
    test_redirect();
    test_pc_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
